// File: rtl/modexp_pkg.sv
// Shared widths and encodings for the modular-exponentiation controller.
package modexp_pkg;

    localparam int N  = 512;          // operand / modulus width
    localparam int MW = N + 2;        // Montgomery multiplier port width
    localparam int EW = 10;           // exponent-length width
    localparam int IW = $clog2(N);    // bit index into the exponent register

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_TOMONT   = 2'd0,
        OP_SQR      = 2'd1,
        OP_MUL      = 2'd2,
        OP_FROMMONT = 2'd3
    } op_t;

    // Multiplier ports are two bits wider than the operands; upper bits are zero.
    function automatic logic [MW-1:0] zext(input logic [N-1:0] v);
        return {2'b00, v};
    endfunction

endpackage

// File: rtl/modexp_ctrl.sv
// X^E mod M by left-to-right square-and-multiply in the Montgomery domain.
// All arithmetic is done by an external start/done Montgomery multiplier;
// this block only holds operands, scans the exponent and sequences operations.
//
// Handshake with the multiplier: mm_start is a one-cycle pulse in ISSUE with
// mm_a/mm_b/mm_m already stable; they are held until mm_done is seen in WAIT,
// the cycle in which mm_result is captured. mm_done outside WAIT is ignored.
module modexp_ctrl
    import modexp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  in_x,
    input  logic [N-1:0]  in_e,
    input  logic [EW-1:0] in_e_len,
    input  logic [N-1:0]  in_m,
    input  logic [N-1:0]  in_r,
    input  logic [N-1:0]  in_r2,
    output logic [N-1:0]  result,
    output logic          done,
    output logic          busy,
    output logic          mm_start,
    output logic [MW-1:0] mm_a,
    output logic [MW-1:0] mm_b,
    output logic [MW-1:0] mm_m,
    input  logic [MW-1:0] mm_result,
    input  logic          mm_done,
    output state_t        o_dbg_state,
    output op_t           o_dbg_op
);

    state_t          r_state;
    op_t             r_op;
    logic [N-1:0]    r_x, r_e, r_r2, r_a, r_xm, r_result;
    logic [EW-1:0]   r_i;
    logic            r_done, r_busy, r_mm_start;
    logic [MW-1:0]   r_mm_a, r_mm_b, r_mm_m;

    logic [N-1:0]    w_prod, w_a_next, w_xm_next;
    logic [EW-1:0]   w_i_m1, w_i_next;
    logic [IW-1:0]   w_idx;
    logic            w_e_bit, w_finish;
    op_t             w_op_next;
    logic [MW-1:0]   w_opa, w_opb;
    logic            w_unused_hi;

    // Only the low N bits of the multiplier result carry the reduced value.
    assign w_prod      = mm_result[N-1:0];
    assign w_unused_hi = ^mm_result[MW-1:N];

    // Current exponent bit E[i-1]; only consulted while i > 0.
    assign w_i_m1  = r_i - EW'(1);
    assign w_idx   = w_i_m1[IW-1:0];
    assign w_e_bit = r_e[w_idx];

    // TOMONT lands in Xm, every other operation in A.
    assign w_a_next  = (r_op != OP_TOMONT) ? w_prod : r_a;
    assign w_xm_next = (r_op == OP_TOMONT) ? w_prod : r_xm;

    // Choose the operation that follows the one just completed.
    always_comb begin
        w_op_next = r_op;
        w_i_next  = r_i;
        w_finish  = 1'b0;
        case (r_op)
            OP_TOMONT: begin
                w_op_next = (r_i != '0) ? OP_SQR : OP_FROMMONT;
            end
            OP_SQR: begin
                if (w_e_bit) begin
                    w_op_next = OP_MUL;
                end else begin
                    w_i_next  = w_i_m1;
                    w_op_next = (w_i_m1 != '0) ? OP_SQR : OP_FROMMONT;
                end
            end
            OP_MUL: begin
                w_i_next  = w_i_m1;
                w_op_next = (w_i_m1 != '0) ? OP_SQR : OP_FROMMONT;
            end
            OP_FROMMONT: begin
                w_finish = 1'b1;
            end
            default: begin
                w_finish = 1'b0;
            end
        endcase
    end

    // Operand select for the next operation, using the freshly captured values.
    always_comb begin
        w_opa = zext(r_x);
        w_opb = zext(r_r2);
        case (w_op_next)
            OP_TOMONT: begin
                w_opa = zext(r_x);
                w_opb = zext(r_r2);
            end
            OP_SQR: begin
                w_opa = zext(w_a_next);
                w_opb = zext(w_a_next);
            end
            OP_MUL: begin
                w_opa = zext(w_a_next);
                w_opb = zext(w_xm_next);
            end
            OP_FROMMONT: begin
                w_opa = zext(w_a_next);
                w_opb = zext(N'(1));
            end
            default: begin
                w_opa = zext(r_x);
            end
        endcase
    end

    // Sequencing FSM with registered outputs and the operand datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_TOMONT;
            r_x        <= '0;
            r_e        <= '0;
            r_r2       <= '0;
            r_a        <= '0;
            r_xm       <= '0;
            r_i        <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_mm_start <= 1'b0;
            r_mm_a     <= '0;
            r_mm_b     <= '0;
            r_mm_m     <= '0;
        end else begin
            r_done     <= 1'b0;
            r_mm_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x        <= in_x;
                        r_e        <= in_e;
                        r_r2       <= in_r2;
                        r_a        <= in_r;
                        r_i        <= in_e_len;
                        r_op       <= OP_TOMONT;
                        r_mm_a     <= zext(in_x);
                        r_mm_b     <= zext(in_r2);
                        r_mm_m     <= zext(in_m);
                        r_mm_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mm_done) begin
                        r_a  <= w_a_next;
                        r_xm <= w_xm_next;
                        r_i  <= w_i_next;
                        if (w_finish) begin
                            r_result <= w_a_next;
                            r_done   <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_op       <= w_op_next;
                            r_mm_a     <= w_opa;
                            r_mm_b     <= w_opb;
                            r_mm_start <= 1'b1;
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign result      = r_result;
    assign done        = r_done;
    assign busy        = r_busy;
    assign mm_start    = r_mm_start;
    assign mm_a        = r_mm_a;
    assign mm_b        = r_mm_b;
    assign mm_m        = r_mm_m;
    assign o_dbg_state = r_state;
    assign o_dbg_op    = r_op;

endmodule

// File: doc/modexp_ctrl.md
# modexp_ctrl

Modular-exponentiation controller that computes X^E mod M by driving the existing start/done Montgomery multiplier as its initiator. It owns the operand registers, the exponent scan and the operation sequencing. The multiplier does all arithmetic; this block contains no adder. The top level instantiates this block and the multiplier side by side on the same clock and reset.

## Interface
- N, 512: operand/modulus width.
- MW, N+2: multiplier port width.
- EW, 10: exponent-length width.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- in_x  in  N  base, x < M.
- in_e  in  N  exponent; bits [in_e_len-1:0] used.
- in_e_len  in  EW  exponent bit count, 0..N.
- in_m  in  N  odd modulus.
- in_r  in  N  R mod M, with R = 2^N.
- in_r2  in  N  R² mod M.
- result  out  N  X^E mod M; valid when done=1, held until next start.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- mm_start  out  1  one-cycle multiply request.
- mm_a, mm_b, mm_m  out  MW  multiplier operands, zero-extended ({2'b00, reg}).
- mm_result  in  MW  multiplier output; only [N-1:0] used.
- mm_done  in  1  multiplier completion; only honoured in WAIT.

## Operation
- IDLE with start=1: latch all inputs into X, E, M, R2 and A ← in_r. Set i ← in_e_len and op ← TOMONT. Next state is ISSUE.
- Operation sequence is left-to-right square-and-multiply in the Montgomery domain:
  - TOMONT: Xm = mont(X, R2).
  - For each bit from i-1 down to 0: SQR A = mont(A, A); then, if E[i-1]=1, MUL A = mont(A, Xm).
  - FROMMONT: A = mont(A, 1).
- TOMONT writes its result to Xm; every other operation writes to A.
- ISSUE: assert mm_start for exactly one cycle, with mm_a/mm_b selected by op and mm_m = M. Next state is WAIT.
- mm_a, mm_b and mm_m stay stable from ISSUE until mm_done is seen.
- WAIT: stay until mm_done=1. In that cycle, capture mm_result[N-1:0] into the destination, then choose the next op:
  - TOMONT → SQR if i>0, else FROMMONT.
  - SQR → MUL if E[i-1]=1; otherwise decrement i, then SQR if i>0, else FROMMONT.
  - MUL → decrement i, then SQR if i>0, else FROMMONT.
  - FROMMONT → DONE.
- DONE: drive result = A and done=1 for one cycle, then return to IDLE.
- State set is IDLE, ISSUE, WAIT, DONE; op ∈ {TOMONT, SQR, MUL, FROMMONT}.
- Multiplication count is 2 + e_len + popcount(E[e_len-1:0]).
- e_len=0 runs TOMONT then FROMMONT and yields 1 mod M.
- Reset value of every output is 0, including result and all mm_* ports.
- start while busy is ignored, and the latched operands are unchanged.
- rst during any state → IDLE next cycle, all outputs 0, i cleared.
- The multiplier shares rst, so no stale mm_done survives a reset.
- The multiplier returns a fully reduced result (< M). No final subtraction is done here.

## Timing
- Start is accepted in cycle t; ISSUE is cycle t+1.
- Per multiplication: 1 ISSUE cycle plus W_k WAIT cycles, where W_k counts up to and including the mm_done cycle.
- The decision is made in the mm_done cycle; the next ISSUE, or DONE, follows in the next cycle.
- Total latency from start to done = 1 + Σ(1 + W_k) cycles.
- The minimum multiplier latency of 1 (mm_done in the cycle after mm_start) must work.
- done is registered. A start in the cycle after done is accepted.

## Structure
- Shared package modexp_pkg holds N, MW, EW, the state encodings and the op encodings.
- No sub-module: the block is a single FSM with a datapath of A, Xm, E, M, R2 and counter i.
- The Montgomery multiplier stays external, connected through the mm_* ports.

## Test plan
All tests use a bench multiplier model with programmable latency 1..20 that computes a·b·2^-N mod m.
- Small case: M=13, x=2, E=5, e_len=3 (R, R² from the model) → result 6, exactly 7 mm_start pulses.
- Zero-length exponent: e_len=0, any x → result 1, exactly 2 mm_start pulses, latency 1+2·(1+W).
- Full-length exponent: E = 2^512-1, e_len=512, x=M-1, M = a 512-bit odd random → result M-1, 1026 pulses.
- Start ignored while busy: start held high throughout, with in_x changed mid-run → result uses the originally latched x, exactly one done pulse.
- Reset mid-run: rst in a WAIT cycle → next cycle busy=done=mm_start=0. A fresh start then produces the correct result.
- Back-to-back runs: start in the cycle after done → accepted. Two consecutive correct results with multiplier latency 1.
